// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants and types for the iterative CORDIC engine
// Holds the arctangent table, the mode encoding and the controller state type.
// Table entry i is round(atan(2^-i) * 2^31 / pi). It is scaled for a 32-bit binary
// angle; narrower engines round it down in cordic_atan_rom.
package cordic_pkg;

    localparam int ATAN_ENTRIES = 32;

    localparam logic [31:0] ATAN_TABLE [ATAN_ENTRIES] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
    };

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// rtl/cordic_atan_rom.sv - combinational arctangent lookup rounded to WIDTH bits
// Ports:
//   i_idx  - micro-rotation index (0..31)
//   o_atan - atan(2^-i_idx) as an unsigned WIDTH-bit binary angle
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [4:0]       i_idx,
    output logic [WIDTH-1:0] o_atan
);

    logic [31:0] w_entry;

    assign w_entry = ATAN_TABLE[i_idx];

    generate
        if (WIDTH < 32) begin : g_round
            // Round-half-up: add the first discarded bit to the truncated value.
            assign o_atan = WIDTH'(w_entry >> (32 - WIDTH)) + WIDTH'(w_entry[31-WIDTH]);
        end else begin : g_full
            assign o_atan = w_entry;
        end
    endgenerate

endmodule

// File: rtl/cordic_seq.sv
// rtl/cordic_seq.sv - iterative CORDIC, one micro-rotation per clock, rotation and vectoring
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - operand handshake; in_ready is high only while idle
//   in_mode               - 0 rotation, 1 vectoring
//   in_x, in_y, in_z      - signed operands; in_z is a binary angle (ignored in vectoring)
//   out_valid / out_ready - result handshake; result held until accepted
//   out_x, out_y          - WIDTH+2 bit results carrying the uncompensated CORDIC gain
//   out_z                 - residual angle (rotation) or atan2(y, x) (vectoring)
module cordic_seq
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic signed [WIDTH-1:0] in_z,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH+1:0] out_x,
    output logic signed [WIDTH+1:0] out_y,
    output logic signed [WIDTH-1:0] out_z
);

    localparam int XW = WIDTH + 2;
    localparam logic [WIDTH-1:0] Z_PI = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    state_t r_state;
    state_t w_state_next;

    logic [4:0]              r_iter;
    logic                    r_mode;
    logic signed [XW-1:0]    r_x;
    logic signed [XW-1:0]    r_y;
    logic [WIDTH-1:0]        r_z;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic signed [XW-1:0]    r_out_x;
    logic signed [XW-1:0]    r_out_y;
    logic signed [WIDTH-1:0] r_out_z;

    logic                    w_accept;
    logic signed [XW-1:0]    w_in_x_ext;
    logic signed [XW-1:0]    w_in_y_ext;
    logic signed [XW-1:0]    w_pre_x;
    logic signed [XW-1:0]    w_pre_y;
    logic [WIDTH-1:0]        w_pre_z;
    logic [WIDTH-1:0]        w_atan;
    logic                    w_dir_pos;
    logic signed [XW-1:0]    w_x_shr;
    logic signed [XW-1:0]    w_y_shr;
    logic signed [XW-1:0]    w_x_next;
    logic signed [XW-1:0]    w_y_next;
    logic [WIDTH-1:0]        w_z_next;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_z     = r_out_z;

    assign w_accept = (r_state == ST_IDLE) && in_valid && r_in_ready;

    // Widen before negating so that negating the most negative input cannot overflow.
    assign w_in_x_ext = {{2{in_x[WIDTH-1]}}, in_x};
    assign w_in_y_ext = {{2{in_y[WIDTH-1]}}, in_y};

    // Pre-rotation by pi brings the problem into the +/- pi/2 convergence range.
    always_comb begin
        w_pre_x = w_in_x_ext;
        w_pre_y = w_in_y_ext;
        w_pre_z = in_z;
        if (in_mode == MODE_ROT) begin
            if (in_z[WIDTH-1] != in_z[WIDTH-2]) begin
                w_pre_x = -w_in_x_ext;
                w_pre_y = -w_in_y_ext;
                w_pre_z = in_z ^ Z_PI;
            end
        end else begin
            w_pre_z = '0;
            if (in_x[WIDTH-1]) begin
                w_pre_x = -w_in_x_ext;
                w_pre_y = -w_in_y_ext;
                w_pre_z = Z_PI;
            end
        end
    end

    cordic_atan_rom #(
        .WIDTH (WIDTH)
    ) u_atan_rom (
        .i_idx  (r_iter),
        .o_atan (w_atan)
    );

    // Rotation drives z toward zero; vectoring drives y toward zero.
    assign w_dir_pos = (r_mode == MODE_ROT) ? ~r_z[WIDTH-1] : r_y[XW-1];
    assign w_x_shr   = r_x >>> r_iter;
    assign w_y_shr   = r_y >>> r_iter;

    always_comb begin
        w_x_next = r_x + w_y_shr;
        w_y_next = r_y - w_x_shr;
        w_z_next = r_z + w_atan;
        if (w_dir_pos) begin
            w_x_next = r_x - w_y_shr;
            w_y_next = r_y + w_x_shr;
            w_z_next = r_z - w_atan;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_RUN;
            ST_RUN:  if (r_iter == LAST_ITER) w_state_next = ST_DONE;
            ST_DONE: if (r_out_valid && out_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_iter      <= '0;
            r_mode      <= MODE_ROT;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_z     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_x    <= w_pre_x;
                        r_y    <= w_pre_y;
                        r_z    <= w_pre_z;
                        r_mode <= in_mode;
                        r_iter <= '0;
                    end
                end
                ST_RUN: begin
                    r_x    <= w_x_next;
                    r_y    <= w_y_next;
                    r_z    <= w_z_next;
                    r_iter <= r_iter + 5'd1;
                end
                ST_DONE: begin
                    // First DONE cycle captures the result; it is then held until accepted.
                    if (!r_out_valid) begin
                        r_out_x     <= r_x;
                        r_out_y     <= r_y;
                        r_out_z     <= r_z;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_seq.sv
// tb/tb_cordic_seq.sv - scoreboard testbench for cordic_seq against a real-valued model
module tb_cordic_seq;

    localparam int  W    = 16;
    localparam int  ITER = 15;
    localparam int  XW   = W + 2;
    localparam int  TMO  = 200;
    localparam real PI   = 3.14159265358979323846;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_mode;
    logic signed [W-1:0]  in_x;
    logic signed [W-1:0]  in_y;
    logic signed [W-1:0]  in_z;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [XW-1:0] out_x;
    logic signed [XW-1:0] out_y;
    logic signed [W-1:0]  out_z;

    always #5 clk = ~clk;

    cordic_seq #(
        .WIDTH (W),
        .ITER  (ITER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_z      (in_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z)
    );

    typedef struct {
        longint x;
        longint y;
        longint z;
        longint txy;
        longint tz;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    real  k_gain;

    task automatic check_val(input string tag, input longint obs, input longint exp,
                             input longint tol, input bit wrap);
        longint       d;
        logic [W-1:0] d_w;
        n_checks++;
        d = obs - exp;
        if (wrap) begin
            d_w = d[W-1:0];
            d   = longint'($signed(d_w));
        end
        if (d < 0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    function automatic exp_t model(input bit mode, input longint x, input longint y,
                                   input longint z, input longint txy, input longint tz);
        exp_t e;
        real  rx;
        real  ry;
        real  phi;
        rx = real'(x);
        ry = real'(y);
        if (!mode) begin
            phi = real'(z) * PI / 32768.0;
            e.x = longint'(k_gain * (rx * $cos(phi) - ry * $sin(phi)));
            e.y = longint'(k_gain * (rx * $sin(phi) + ry * $cos(phi)));
            e.z = 0;
        end else begin
            e.x = longint'(k_gain * $sqrt(rx * rx + ry * ry));
            e.y = 0;
            e.z = longint'($atan2(ry, rx) * 32768.0 / PI);
        end
        e.txy = txy;
        e.tz  = tz;
        return e;
    endfunction

    task automatic send(input bit mode, input longint x, input longint y, input longint z,
                        input longint txy, input longint tz);
        int w = 0;
        while (!in_ready && w < TMO) begin
            @(negedge clk);
            w++;
        end
        check_val("in_ready_wait", longint'(in_ready), 1, 0, 0);
        in_mode  = mode;
        in_x     = W'(x);
        in_y     = W'(y);
        in_z     = W'(z);
        in_valid = 1'b1;
        sb_q.push_back(model(mode, x, y, z, txy, tz));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic receive(input int hold, input bit check_lat);
        int   lat = 0;
        exp_t e;
        while (!out_valid && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        check_val("out_valid_wait", longint'(out_valid), 1, 0, 0);
        if (check_lat) check_val("latency", lat, ITER + 1, 0, 0);
        check_val("sb_depth", sb_q.size(), 1, 0, 0);
        e = '{default: 0};
        if (sb_q.size() > 0) e = sb_q.pop_front();
        for (int c = 0; c < hold; c++) begin
            in_valid = 1'b1;
            in_mode  = 1'b1;
            in_x     = W'($urandom);
            in_y     = W'($urandom);
            check_val("bp_valid", longint'(out_valid), 1, 0, 0);
            check_val("bp_in_ready", longint'(in_ready), 0, 0, 0);
            check_val("bp_x", longint'(out_x), e.x, e.txy, 0);
            check_val("bp_y", longint'(out_y), e.y, e.txy, 0);
            check_val("bp_z", longint'(out_z), e.z, e.tz, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_val("out_x", longint'(out_x), e.x, e.txy, 0);
        check_val("out_y", longint'(out_y), e.y, e.txy, 0);
        check_val("out_z", longint'(out_z), e.z, e.tz, 1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val("post_accept_valid", longint'(out_valid), 0, 0, 0);
        check_val("post_accept_ready", longint'(in_ready), 1, 0, 0);
    endtask

    initial begin
        real    p;
        longint rx;
        longint ry;
        longint rz;
        bit     rmode;

        k_gain = 1.0;
        p      = 1.0;
        for (int i = 0; i < ITER; i++) begin
            k_gain = k_gain * $sqrt(1.0 + p);
            p      = p * 0.25;
        end

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_z      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_in_ready", longint'(in_ready), 1, 0, 0);
        check_val("rst_out_valid", longint'(out_valid), 0, 0, 0);
        check_val("rst_out_x", longint'(out_x), 0, 0, 0);
        check_val("rst_out_y", longint'(out_y), 0, 0, 0);
        check_val("rst_out_z", longint'(out_z), 0, 0, 0);

        // Directed rotation, including both pre-rotation cases.
        send(0, 16384, 0, 0, 4, 2);          receive(0, 1);
        send(0, 16384, 0, 16384, 4, 2);      receive(0, 1);
        send(0, 16384, 0, -32768, 4, 2);     receive(0, 1);

        // Directed vectoring.
        send(1, 0, 16384, 0, 4, 2);          receive(0, 1);
        send(1, 16384, 16384, 0, 6, 2);      receive(0, 1);
        send(1, -16384, 0, 0, 4, 2);         receive(0, 1);

        // Back-pressure with junk on the input side, then a clean follow-up.
        send(0, 12000, -7000, 5000, 24, 2);  receive(5, 1);
        send(1, 20000, -9000, 0, 16, 8);     receive(0, 1);

        // Reset in the middle of RUN with in_valid held through it.
        send(0, 16384, 0, 16384, 4, 2);
        repeat (6) @(negedge clk);
        check_val("run_in_ready", longint'(in_ready), 0, 0, 0);
        rst      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check_val("mid_rst_valid", longint'(out_valid), 0, 0, 0);
        check_val("mid_rst_x", longint'(out_x), 0, 0, 0);
        check_val("mid_rst_y", longint'(out_y), 0, 0, 0);
        check_val("mid_rst_z", longint'(out_z), 0, 0, 0);
        check_val("mid_rst_ready", longint'(in_ready), 1, 0, 0);
        sb_q.delete();
        rst = 1'b0;
        send(1, 16384, 16384, 0, 6, 2);      receive(0, 1);

        // Most-negative corners must not overflow.
        send(1, -32768, -32768, 0, 16, 4);   receive(0, 1);
        send(0, -32768, -32768, 0, 24, 2);   receive(0, 1);

        // Randomised sweep over both modes.
        for (int n = 0; n < 300; n++) begin
            rmode = 1'($urandom_range(0, 1));
            if (!rmode) begin
                rx = longint'($urandom_range(0, 32768)) - 16384;
                ry = longint'($urandom_range(0, 32768)) - 16384;
                rz = longint'($urandom_range(0, 65535)) - 32768;
                send(0, rx, ry, rz, 24, 2);
            end else begin
                do begin
                    rx = longint'($urandom_range(0, 65534)) - 32767;
                    ry = longint'($urandom_range(0, 65534)) - 32767;
                end while (rx * rx + ry * ry < 64'd268435456);
                send(1, rx, ry, 0, 16, 8);
            end
            receive(int'($urandom_range(0, 2)), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
